prd_cmd_port: RTL and testbench

Parametrised command-input / indication port for the BSK PRD board, second generation of the PRD bus slave. Samples CH relay command inputs through a synchroniser and optional debounce filter, presents them to the host in complementary-nibble format, keeps sticky per-channel event latches, drives the command indication LEDs and generates a programmable-frequency test signal. Sits directly on the 16-bit asynchronous host bus (bD/iRd/iWr/iA/iCS).

---
 rtl/prd_cmd_port_if.sv | 13 +
 rtl/prd_cmd_port.sv | 161 ++++++++++++++++
 tb/tb_prd_cmd_port.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prd_cmd_port_if.sv
// Asynchronous PRD host bus strobes, address and chip-select shared by host and command port.
interface prd_cmd_port_if #(
  parameter int ADDR_W = 3
);
  logic              iRd;
  logic              iWr;
  logic [ADDR_W-1:0] iA;
  logic [3:0]        iCS;
  logic              oCS;

  modport master (output iRd, iWr, iA, iCS, input oCS);
  modport slave  (input iRd, iWr, iA, iCS, output oCS);
endinterface

// File: rtl/prd_cmd_port.sv
// PRD command input / indication port: synchronised commands, sticky latches, LEDs, test generator.
// Define PRD_CMD_FILTER_EN to build the per-channel debounce filter (FILT_LEN clk).
module prd_cmd_port #(
  parameter int         CH           = 16,
  parameter int         ADDR_W       = 3,
  parameter logic [6:0] VERSION      = 7'h26,
  parameter logic [7:0] PASSWORD     = 8'hA4,
  parameter logic [3:0] CS           = 4'b1011,
  parameter int         FILT_LEN     = 20,
  parameter logic [7:0] TEST_DIV_DEF = 8'd3
) (
  input  logic          clk,
  input  logic          iRes,
  inout  wire  [15:0]   bD,
  prd_cmd_port_if.slave bus,
  input  logic          iBl,
  input  logic [CH-1:0] iCom,
  output logic [CH-1:0] oComInd,
  output logic          oTest
);
  localparam int BANKS = CH / 16;

  logic [CH-1:0]     com_s1, com_s2, filt, filt_d, rise;
  logic [CH-1:0]     latch, latch_clr, ind;
  logic              wr_s1, wr_s2, wr_armed, commit;
  logic [ADDR_W-1:0] cap_a;
  logic [3:0]        cap_cs;
  logic [15:0]       cap_d;
  logic [31:0]       wr_addr, rd_addr;
  logic              test_en, test_clk;
  logic [7:0]        test_div, test_cnt;
  logic [15:0]       rdata;

  always_ff @(posedge clk or negedge iRes) begin
    if (!iRes) begin
      com_s1 <= '0;
      com_s2 <= '0;
      filt_d <= '0;
    end else begin
      com_s1 <= iCom;
      com_s2 <= com_s1;
      filt_d <= filt;
    end
  end

`ifdef PRD_CMD_FILTER_EN
  logic [7:0]    filt_cnt [CH];
  logic [CH-1:0] filt_q;

  // Counter tracks consecutive samples disagreeing with the filtered value.
  always_ff @(posedge clk or negedge iRes) begin
    if (!iRes) begin
      filt_q <= '0;
      for (int n = 0; n < CH; n++) filt_cnt[n] <= '0;
    end else begin
      for (int n = 0; n < CH; n++) begin
        if (com_s2[n] == filt_q[n]) begin
          filt_cnt[n] <= '0;
        end else if (filt_cnt[n] == 8'(FILT_LEN - 1)) begin
          filt_q[n]   <= ~filt_q[n];
          filt_cnt[n] <= '0;
        end else begin
          filt_cnt[n] <= filt_cnt[n] + 8'd1;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = com_s2;
`endif

  assign rise = filt & ~filt_d;

  // Write arms only on a seen falling edge, so a reset during a write drops it.
  always_ff @(posedge clk or negedge iRes) begin
    if (!iRes) begin
      wr_s1    <= 1'b0;
      wr_s2    <= 1'b0;
      wr_armed <= 1'b0;
      cap_a    <= '0;
      cap_cs   <= '0;
      cap_d    <= '0;
    end else begin
      wr_s1 <= bus.iWr;
      wr_s2 <= wr_s1;
      if (wr_s2 && !wr_s1)
        wr_armed <= 1'b1;
      else if (wr_s1 && !wr_s2)
        wr_armed <= 1'b0;
      if (!wr_s2) begin
        cap_a  <= bus.iA;
        cap_cs <= bus.iCS;
        cap_d  <= bD;
      end
    end
  end

  assign commit  = wr_s1 && !wr_s2 && wr_armed && (cap_cs == CS);
  assign wr_addr = 32'(cap_a);

  always_comb begin
    latch_clr = '0;
    for (int k = 0; k < BANKS; k++)
      if (commit && wr_addr == 32'(2 * BANKS + k))
        latch_clr[16*k +: 16] = cap_d;
  end

  // Set is OR-ed in after the clear so a coincident edge survives.
  always_ff @(posedge clk or negedge iRes) begin
    if (!iRes) begin
      latch    <= '0;
      ind      <= '0;
      test_en  <= 1'b0;
      test_div <= TEST_DIV_DEF;
    end else begin
      latch <= (latch & ~latch_clr) | rise;
      if (commit) begin
        for (int k = 0; k < BANKS; k++)
          if (wr_addr == 32'(3 * BANKS + k))
            ind[16*k +: 16] <= cap_d;
        if (wr_addr == 32'(4 * BANKS)) begin
          test_en  <= cap_d[0];
          test_div <= cap_d[11:4];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge iRes) begin
    if (!iRes) begin
      test_cnt <= '0;
      test_clk <= 1'b0;
    end else if (test_cnt == 8'd0) begin
      test_cnt <= test_div;
      test_clk <= ~test_clk;
    end else begin
      test_cnt <= test_cnt - 8'd1;
    end
  end

  always_comb begin
    rdata   = '0;
    rd_addr = 32'(bus.iA);
    for (int w = 0; w < 2 * BANKS; w++)
      if (rd_addr == 32'(w))
        rdata = {~filt[8*w+4 +: 4], filt[8*w+4 +: 4], ~filt[8*w +: 4], filt[8*w +: 4]};
    for (int k = 0; k < BANKS; k++) begin
      if (rd_addr == 32'(2 * BANKS + k)) rdata = latch[16*k +: 16];
      if (rd_addr == 32'(3 * BANKS + k)) rdata = ind[16*k +: 16];
    end
    if (rd_addr == 32'(4 * BANKS))     rdata = {4'h0, test_div, 3'b000, test_en};
    if (rd_addr == 32'(4 * BANKS + 1)) rdata = {PASSWORD, VERSION, test_en};
  end

  assign bD      = ((bus.iCS == CS) && !bus.iRd) ? rdata : 16'hzzzz;
  assign bus.oCS = (bus.iCS != CS);
  assign oComInd = ~ind;
  assign oTest   = iBl && test_en && test_clk;
endmodule

// File: tb/tb_prd_cmd_port.sv
// Scoreboard bench for prd_cmd_port: bus reads/writes, latches, indication and test generator.
`timescale 1ns/1ps
module tb_prd_cmd_port;
  localparam int         CH       = 16;
  localparam int         ADDR_W   = 3;
  localparam int         FILT_LEN = 20;
  localparam logic [3:0] CS       = 4'b1011;
`ifdef PRD_CMD_FILTER_EN
  localparam int CmdLat = 2 + FILT_LEN;
`else
  localparam int CmdLat = 2;
`endif
  // The latch sets one clk after the filtered bit rises.
  localparam int SetLat = CmdLat + 1;

  logic          clk = 1'b0;
  logic          iRes;
  logic          iBl;
  logic [CH-1:0] iCom;
  logic [CH-1:0] oComInd;
  logic          oTest;
  wire  [15:0]   bD;
  logic [15:0]   hostData;
  logic          hostDrive;

  int            compared   = 0;
  int            mismatched = 0;
  string         tagQ[$];
  logic [31:0]   valQ[$];

  prd_cmd_port_if #(.ADDR_W(ADDR_W)) bus ();

  assign bD = hostDrive ? hostData : 16'hzzzz;

  prd_cmd_port #(.CH(CH), .ADDR_W(ADDR_W), .FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .iRes(iRes), .bD(bD), .bus(bus), .iBl(iBl),
    .iCom(iCom), .oComInd(oComInd), .oTest(oTest)
  );

  always #250 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] value);
    tagQ.push_back(tag);
    valQ.push_back(value);
  endtask

  task automatic popCompare(input logic [31:0] observed);
    if (valQ.size() == 0)
      checkOutput("scoreboard_underflow", 32'(valQ.size()), 32'd1);
    else
      checkOutput(tagQ.pop_front(), observed, valQ.pop_front());
  endtask

  task automatic readBus(input logic [ADDR_W-1:0] addr, output logic [15:0] data);
    @(negedge clk);
    bus.iA  = addr;
    bus.iCS = CS;
    bus.iRd = 1'b0;
    #20;
    data    = bD;
    bus.iRd = 1'b1;
    bus.iCS = 4'h0;
  endtask

  task automatic expectRead(input string tag, input logic [ADDR_W-1:0] addr, input logic [15:0] value);
    logic [15:0] data;
    pushExpect(tag, {16'h0, value});
    readBus(addr, data);
    popCompare({16'h0, data});
  endtask

  // Host write: strobe low 4 clk, data held 3 clk past the rising strobe.
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [15:0] data, input logic [3:0] cs);
    @(negedge clk);
    bus.iA    = addr;
    bus.iCS   = cs;
    hostData  = data;
    hostDrive = 1'b1;
    bus.iWr   = 1'b0;
    repeat (4) @(negedge clk);
    bus.iWr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    hostDrive = 1'b0;
    bus.iCS   = 4'h0;
  endtask

  task automatic measurePeriod(output int period);
    int   first;
    logic prev;
    period = -1;
    first  = -1;
    @(negedge clk);
    prev = oTest;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (oTest && !prev) begin
        if (first < 0) first = n;
        else begin
          period = n - first;
          break;
        end
      end
      prev = oTest;
    end
  endtask

  task automatic doReset();
    iRes = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    iRes = 1'b1;
  endtask

  initial begin
    #20ms;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          period;
    int          highs;
    int          lat;
    int          t;
    int          lead;
    logic [15:0] data;

    bus.iRd = 1'b1;  bus.iWr = 1'b1;  bus.iA = '0;  bus.iCS = 4'h0;
    hostDrive = 1'b0;  hostData = '0;  iBl = 1'b1;  iCom = '0;  iRes = 1'b1;
    doReset();

    expectRead("reset_id", 3'd5, 16'hA44C);
    expectRead("reset_ctrl", 3'd4, 16'h0030);
    expectRead("unmapped_addr6", 3'd6, 16'h0000);
    pushExpect("reset_oComInd", 32'h0000FFFF);
    popCompare({16'h0, oComInd});
    pushExpect("reset_oTest", 32'd0);
    popCompare({31'h0, oTest});

    @(negedge clk);
    bus.iCS = CS;
    #1;
    pushExpect("oCS_selected", 32'd0);
    popCompare({31'h0, bus.oCS});
    bus.iCS = 4'b0011;
    #1;
    pushExpect("oCS_other", 32'd1);
    popCompare({31'h0, bus.oCS});
    bus.iCS = 4'h0;

    iCom[0] = 1'b1;
    repeat (25) @(negedge clk);
    expectRead("cmd_word0_ch0", 3'd0, 16'hF0E1);
    expectRead("cmd_word1_idle", 3'd1, 16'hF0F0);
    expectRead("latch_ch0_set", 3'd2, 16'h0001);

    iCom[1] = 1'b1;
    repeat (10) @(negedge clk);
    iCom[1] = 1'b0;
    repeat (30) @(negedge clk);
    expectRead("cmd_after_glitch", 3'd0, 16'hF0E1);
`ifdef PRD_CMD_FILTER_EN
    expectRead("latch_glitch_rejected", 3'd2, 16'h0001);
`else
    expectRead("latch_glitch_passed", 3'd2, 16'h0003);
    applyStimulus(3'd2, 16'h0002, CS);
    expectRead("latch_w1c_bit1", 3'd2, 16'h0001);
`endif

    iCom[0] = 1'b0;
    repeat (CmdLat + 4) @(negedge clk);
    expectRead("cmd_ch0_low", 3'd0, 16'hF0F0);
    applyStimulus(3'd2, 16'h0001, CS);
    expectRead("latch_cleared", 3'd2, 16'h0000);

    // Line up a new iCom[0] edge so its latch set lands on the W1C commit edge.
    lead = SetLat - 2;
    t    = (lead > 4) ? lead : 4;
    @(negedge clk);
    for (int c = 0; c <= t; c++) begin
      if (c == t - 4) begin
        bus.iA = 3'd2;  bus.iCS = CS;  hostData = 16'h0001;  hostDrive = 1'b1;  bus.iWr = 1'b0;
      end
      if (c == t - lead) iCom[0] = 1'b1;
      if (c == t) bus.iWr = 1'b1;
      if (c < t) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    hostDrive = 1'b0;
    bus.iCS   = 4'h0;
    expectRead("latch_set_wins", 3'd2, 16'h0001);
    applyStimulus(3'd2, 16'h0001, CS);
    expectRead("latch_clear_no_edge", 3'd2, 16'h0000);

    applyStimulus(3'd3, 16'h8001, CS);
    pushExpect("ind_out_8001", 32'h00007FFE);
    popCompare({16'h0, oComInd});
    expectRead("ind_readback", 3'd3, 16'h8001);
    applyStimulus(3'd3, 16'h1234, 4'b0000);
    repeat (2) @(negedge clk);
    pushExpect("ind_wrong_cs", 32'h00007FFE);
    popCompare({16'h0, oComInd});

    applyStimulus(3'd4, 16'h0011, CS);
    expectRead("ctrl_readback", 3'd4, 16'h0011);
    expectRead("id_test_en", 3'd5, 16'hA44D);
    repeat (10) @(negedge clk);
    measurePeriod(period);
    pushExpect("test_period_div1", 32'd4);
    popCompare(32'(period));

    iBl   = 1'b0;
    highs = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (oTest) highs++;
    end
    pushExpect("test_blocked", 32'd0);
    popCompare(32'(highs));
    iBl = 1'b1;

    applyStimulus(3'd4, 16'h0001, CS);
    repeat (10) @(negedge clk);
    measurePeriod(period);
    pushExpect("test_period_div0", 32'd2);
    popCompare(32'(period));

    @(negedge clk);
    bus.iA = 3'd3;  bus.iCS = CS;  hostData = 16'hFFFF;  hostDrive = 1'b1;  bus.iWr = 1'b0;
    repeat (2) @(negedge clk);
    iRes = 1'b0;
    @(negedge clk);
    iRes = 1'b1;
    repeat (3) @(negedge clk);
    bus.iWr = 1'b1;
    repeat (4) @(negedge clk);
    hostDrive = 1'b0;
    bus.iCS   = 4'h0;
    pushExpect("reset_mid_write_out", 32'h0000FFFF);
    popCompare({16'h0, oComInd});
    expectRead("reset_mid_write_ind", 3'd3, 16'h0000);
    expectRead("ctrl_after_reset", 3'd4, 16'h0030);

    @(negedge clk);
    iCom[5] = 1'b1;
    bus.iA  = 3'd0;
    bus.iCS = CS;
    bus.iRd = 1'b0;
    lat     = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bD[9]) begin
        lat = n;
        break;
      end
    end
    bus.iRd = 1'b1;
    bus.iCS = 4'h0;
    pushExpect("cmd_latency_in_range", 32'd1);
    popCompare({31'h0, (lat >= CmdLat - 1) && (lat <= CmdLat + 1)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
